// File: rtl/nco_pkg.sv
// Shared types and constants for the multi-channel NCO phase generator.
package nco_pkg;

    typedef enum logic [1:0] {
        MODE_STOP    = 2'd0,
        MODE_RUN     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_e;

    localparam logic [1:0] SEL_FTW  = 2'd0;
    localparam logic [1:0] SEL_OFS  = 2'd1;
    localparam logic [1:0] SEL_MODE = 2'd2;

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, tuning word, offset, run mode,
// one-shot halt/done tracking and the registered LUT index.
module nco_channel
    import nco_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sample_en,
    input  logic             i_sync,
    input  logic             i_we_ftw,
    input  logic             i_we_ofs,
    input  logic             i_we_mode,
    input  logic [ACC_W-1:0] i_cfg_data,
    output logic [IDX_W-1:0] o_index,
    output logic             o_wrap,
    output logic             o_done
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_ftw;
    logic [ACC_W-1:0] r_ofs;
    logic [1:0]       r_mode;
    logic             r_halted;
    logic             r_done;
    logic             r_wrap;
    logic [IDX_W-1:0] r_idx;

    logic             w_active;
    logic             w_oneshot;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_oneshot_end;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_ofs_sum;
    logic             w_unused_lsb;

    assign w_oneshot     = (r_mode == MODE_ONESHOT);
    assign w_active      = ((r_mode == MODE_RUN) || w_oneshot) && !r_halted;
    assign w_sum         = {1'b0, r_acc} + {1'b0, r_ftw};
    assign w_carry       = w_sum[ACC_W];
    assign w_oneshot_end = w_active && w_oneshot && w_carry;

    // A finished one-shot parks at phase 0 rather than at the wrapped residue.
    assign w_acc_next = !w_active     ? r_acc :
                        w_oneshot_end ? '0    : w_sum[ACC_W-1:0];

    assign w_ofs_sum    = w_acc_next + r_ofs;
    assign w_unused_lsb = ^w_ofs_sum[ACC_W-IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_ftw    <= '0;
            r_ofs    <= '0;
            r_mode   <= MODE_STOP;
            r_halted <= 1'b0;
            r_done   <= 1'b0;
            r_wrap   <= 1'b0;
            r_idx    <= '0;
        end else begin
            if (i_we_ftw)  r_ftw  <= i_cfg_data;
            if (i_we_ofs)  r_ofs  <= i_cfg_data;
            if (i_we_mode) r_mode <= i_cfg_data[1:0];

            if (i_sync) begin
                r_acc  <= '0;
                r_wrap <= 1'b0;
            end else if (i_sample_en) begin
                r_acc  <= w_acc_next;
                r_wrap <= w_active && w_carry;
                r_idx  <= w_ofs_sum[ACC_W-1 -: IDX_W];
            end else begin
                r_wrap <= 1'b0;
            end

            // A mode write re-arms the channel even if this same cycle finished it.
            if (i_we_mode || i_sync) begin
                r_halted <= 1'b0;
            end else if (i_sample_en && w_oneshot_end) begin
                r_halted <= 1'b1;
            end

            if (i_we_mode) begin
                r_done <= 1'b0;
            end else if (!i_sync && i_sample_en && w_oneshot_end) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_index = r_idx;
    assign o_wrap  = r_wrap;
    assign o_done  = r_done;

endmodule

// File: rtl/nco_phase_gen.sv
// Multi-channel NCO phase generator: decodes configuration writes into
// per-channel enables and registers the shared phase_valid strobe.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int IDX_W = 10,
    parameter int NCH   = 2,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_sample_en,
    input  logic                 i_sync,
    input  logic                 i_cfg_we,
    input  logic [CH_W-1:0]      i_cfg_ch,
    input  logic [1:0]           i_cfg_sel,
    input  logic [ACC_W-1:0]     i_cfg_data,
    output logic [NCH*IDX_W-1:0] o_phase_out,
    output logic                 o_phase_valid,
    output logic [NCH-1:0]       o_wrap,
    output logic [NCH-1:0]       o_done
);

    logic r_phase_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase_valid <= 1'b0;
        end else begin
            r_phase_valid <= i_sample_en && !i_sync;
        end
    end

    assign o_phase_valid = r_phase_valid;

    // Channel numbers at or above NCH never match, so such writes are dropped.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic w_hit;

        assign w_hit = i_cfg_we && (i_cfg_ch == CH_W'(g));

        nco_channel #(
            .ACC_W (ACC_W),
            .IDX_W (IDX_W)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_sample_en (i_sample_en),
            .i_sync      (i_sync),
            .i_we_ftw    (w_hit && (i_cfg_sel == SEL_FTW)),
            .i_we_ofs    (w_hit && (i_cfg_sel == SEL_OFS)),
            .i_we_mode   (w_hit && (i_cfg_sel == SEL_MODE)),
            .i_cfg_data  (i_cfg_data),
            .o_index     (o_phase_out[g*IDX_W +: IDX_W]),
            .o_wrap      (o_wrap[g]),
            .o_done      (o_done[g])
        );
    end

endmodule
